// File: rtl/difftest_step_sched_if.sv
// Commit-port, reference-step and checker signals of the difftest step scheduler.
// The slave modport is the scheduler itself; the master modport is the DUT/ref/checker side.
interface difftest_step_sched_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
);
  logic                    c0_valid_i;
  logic [XLEN-1:0]         c0_pc_i;
  logic                    c0_trap_i;
  logic                    c1_valid_i;
  logic [XLEN-1:0]         c1_pc_i;
  logic                    c1_trap_i;

  // Step handshake: a step transfers on a cycle where ref_step_valid_o and
  // ref_step_ready_i are both high at the clock edge; while valid is high and
  // ready is low, valid and ref_step_pc_o stay unchanged.
  logic                    ref_step_valid_o;
  logic                    ref_step_ready_i;
  logic [XLEN-1:0]         ref_step_pc_o;

  logic                    cmp_req_o;
  logic [XLEN-1:0]         cmp_pc_o;
  logic                    cmp_done_i;
  logic                    cmp_pass_i;

  logic                    halt_o;
  logic [2:0]              err_code_o;
  logic [63:0]             retired_cnt_o;
  logic [$clog2(DEPTH):0]  fifo_level_o;
  logic [2:0]              dbg_state;

  modport master (
    output c0_valid_i, c0_pc_i, c0_trap_i,
    output c1_valid_i, c1_pc_i, c1_trap_i,
    output ref_step_ready_i, cmp_done_i, cmp_pass_i,
    input  ref_step_valid_o, ref_step_pc_o, cmp_req_o, cmp_pc_o,
    input  halt_o, err_code_o, retired_cnt_o, fifo_level_o, dbg_state
  );

  modport slave (
    input  c0_valid_i, c0_pc_i, c0_trap_i,
    input  c1_valid_i, c1_pc_i, c1_trap_i,
    input  ref_step_ready_i, cmp_done_i, cmp_pass_i,
    output ref_step_valid_o, ref_step_pc_o, cmp_req_o, cmp_pc_o,
    output halt_o, err_code_o, retired_cnt_o, fifo_level_o, dbg_state
  );
endinterface

// File: rtl/difftest_step_sched.sv
// Buffers up to two commits per cycle, steps the reference model one entry at a
// time and sequences a compare per non-trap entry; halts on the first error.
module difftest_step_sched #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  difftest_step_sched_if.slave  bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int FW  = LW + 1;
  localparam int WDW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_OVERFLOW = 3'd1;
  localparam logic [2:0] E_ORDER    = 3'd2;
  localparam logic [2:0] E_MISMATCH = 3'd3;
  localparam logic [2:0] E_TIMEOUT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CMP   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN:0]   mem [DEPTH];  // {pc, trap}
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [LW-1:0]   count;
  logic [XLEN-1:0] cmp_pc;
  logic [2:0]      err_code;
  logic [63:0]     retired;
  logic [WDW-1:0]  wd_cnt;
  logic            wd_armed;

  logic [1:0]      n_valid;
  logic [1:0]      n_push;
  logic [FW-1:0]   free_after;
  logic [LW-1:0]   count_next;
  logic            running;
  logic            pop;
  logic            head_trap;
  logic            in_cmp;
  logic            cmp_ok;
  logic            cmp_fail;
  logic            order_err;
  logic            ovf_err;
  logic            push_ok;
  logic            timeout_err;
  logic [2:0]      err_next;
  state_t          after_retire;

  always_comb begin
    running    = (state != S_HALT);
    n_valid    = 2'(bus.c0_valid_i) + 2'(bus.c1_valid_i);
    pop        = (state == S_ISSUE) && bus.ref_step_ready_i;
    head_trap  = mem[rd_ptr][0];
    in_cmp     = (state == S_CMP) || (state == S_WAIT);
    cmp_ok     = in_cmp && bus.cmp_done_i && bus.cmp_pass_i;
    cmp_fail   = in_cmp && bus.cmp_done_i && !bus.cmp_pass_i;
    // Free space counts the slot released by this cycle's pop.
    free_after = FW'(DEPTH) - FW'(count) + FW'(pop);
    order_err  = running && bus.c1_valid_i && !bus.c0_valid_i;
    ovf_err    = running && (FW'(n_valid) > free_after);
    push_ok    = running && (n_valid != 2'd0) && !order_err && !ovf_err && !cmp_fail;
    n_push     = push_ok ? n_valid : 2'd0;
    count_next = count + LW'(n_push) - LW'(pop);
    timeout_err = running && wd_armed && (wd_cnt == WDW'(TIMEOUT - 1)) && !push_ok;

    err_next = E_NONE;
    if (cmp_fail)         err_next = E_MISMATCH;
    else if (ovf_err)     err_next = E_OVERFLOW;
    else if (order_err)   err_next = E_ORDER;
    else if (timeout_err) err_next = E_TIMEOUT;

    after_retire = (count_next != '0) ? S_ISSUE : S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= {bus.c0_pc_i, bus.c0_trap_i};
      if (bus.c1_valid_i) mem[wr_ptr + 1'b1] <= {bus.c1_pc_i, bus.c1_trap_i};
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      cmp_pc   <= '0;
      err_code <= E_NONE;
      retired  <= '0;
      wd_cnt   <= '0;
      wd_armed <= 1'b0;
    end else if (running) begin
      if (push_ok) begin
        wr_ptr   <= wr_ptr + PW'(n_push);
        wd_cnt   <= '0;
        wd_armed <= 1'b1;
      end else if (wd_armed) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;

      case (state)
        S_IDLE: begin
          if (count_next != '0) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (pop) begin
            if (head_trap) begin
              retired <= retired + 64'd1;
              state   <= after_retire;
            end else begin
              cmp_pc <= mem[rd_ptr][XLEN:1];
              state  <= S_CMP;
            end
          end
        end
        S_CMP: begin
          if (cmp_ok) begin
            retired <= retired + 64'd1;
            state   <= after_retire;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmp_ok) begin
            retired <= retired + 64'd1;
            state   <= after_retire;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Any error overrides the normal next state; only the first is kept.
      if (err_next != E_NONE) begin
        state    <= S_HALT;
        err_code <= err_next;
      end
    end
  end

  assign bus.ref_step_valid_o = (state == S_ISSUE);
  assign bus.ref_step_pc_o    = (state == S_ISSUE) ? mem[rd_ptr][XLEN:1] : '0;
  assign bus.cmp_req_o        = (state == S_CMP);
  assign bus.cmp_pc_o         = cmp_pc;
  assign bus.halt_o           = (state == S_HALT);
  assign bus.err_code_o       = err_code;
  assign bus.retired_cnt_o    = retired;
  assign bus.fifo_level_o     = count;
  assign bus.dbg_state        = state;

  a_level_bound: assert property (@(posedge clk_i) disable iff (!arst_i) count <= LW'(DEPTH));

endmodule

// File: doc/difftest_step_sched.md
# difftest_step_sched

Commit-stream scheduler for the full-Verilog difftest. It accepts up to two in-order commits per cycle from the DUT commit ports and buffers them in a FIFO. It then steps the reference model one instruction at a time through a valid/ready handshake and sequences a per-instruction compare request to the register/CSR checker. It also detects overflow, port-ordering violations, compare mismatches and commit-stream timeouts, and halts the difftest on the first error.

## Interface
- XLEN, 64, PC/data width
- DEPTH, 16, FIFO entries; power of 2, ≥4
- TIMEOUT, 100000, cycles with no accepted commit before a timeout error; ≥2
- clk_i  in  1  clock; all logic on posedge
- arst_i  in  1  asynchronous, active-low reset
- c0_valid_i / c1_valid_i  in  1  commit-port valid; port 0 is older
- c0_pc_i / c1_pc_i  in  XLEN  committed PC
- c0_trap_i / c1_trap_i  in  1  commit raised a trap; stepped but not compared
- ref_step_valid_o  out  1  one-instruction step request to the reference model
- ref_step_ready_i  in  1  reference model accepts the step
- ref_step_pc_o  out  XLEN  PC of the step at FIFO head
- cmp_req_o  out  1  single-cycle compare request
- cmp_pc_o  out  XLEN  PC under compare; held until cmp_done_i
- cmp_done_i  in  1  checker finished
- cmp_pass_i  in  1  compare result; qualified by cmp_done_i
- halt_o  out  1  sticky; difftest stopped
- err_code_o  out  3  0 none, 1 overflow, 2 order, 3 mismatch, 4 timeout
- retired_cnt_o  out  64  instructions stepped and either passed or skipped
- fifo_level_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FIFO entry is {pc, trap}. Enqueue order is c0 then c1. Both ports valid → two entries in one cycle.
- c1_valid_i without c0_valid_i is an order error. Nothing is enqueued that cycle.
- Valid-commit count greater than free entries after this cycle's pop is an overflow error. Nothing is enqueued that cycle.
- FSM states:
  - IDLE: FIFO empty. Go to ISSUE when level is nonzero.
  - ISSUE: ref_step_valid_o=1 with the head PC. On ready, pop the head.
    - Head trap=1: retired_cnt++. Next state is ISSUE if entries remain, otherwise IDLE.
    - Head trap=0: latch cmp_pc_o and go to CMP.
  - CMP: cmp_req_o=1 for exactly this one cycle. Go to WAIT.
  - WAIT: on cmp_done_i & cmp_pass_i, retired_cnt++ and go to ISSUE or IDLE. On cmp_done_i & !cmp_pass_i, go to HALT with error 3. cmp_done_i seen in CMP is treated identically to WAIT.
  - HALT: terminal until reset.
- In HALT: all commits are ignored, ref_step_valid_o=0, cmp_req_o=0, counters frozen. err_code_o holds the first error.
- Watchdog:
  - Increments every non-HALT cycle and clears on any successful enqueue.
  - Not armed until the first commit after reset.
  - Reaching TIMEOUT-1 → HALT with error 4.
- Simultaneous errors in one cycle, priority: mismatch > overflow > order > timeout.
- Enqueue and pop in the same cycle are legal. Level = level + pushes − pop. Pointers wrap mod DEPTH.
- retired_cnt_o wraps at 2^64.

## Timing
- Reset values: every output is 0; FSM=IDLE; FIFO empty; watchdog disarmed.
- Reset asserted mid-operation clears everything asynchronously, including HALT.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Commit at edge N into an empty FIFO with FSM=IDLE → ref_step_valid_o high from N+1.
- Step accepted at edge M → cmp_req_o high during cycle M+1 → WAIT from M+2.
- ref_step_valid_o and ref_step_pc_o hold stable until ready is sampled high.
- Minimum throughput: trap entry, 1 step per cycle; compared entry, 3 cycles when cmp_done_i arrives in the cycle after cmp_req_o.
- halt_o and err_code_o rise at the edge following the error condition.

## Test plan
- **Dual commit, compare pass.** Single cycle with c0 pc=0x80000000 and c1 pc=0x80000004; ready=1; cmp_done_i=cmp_pass_i=1 the cycle after each req → two steps in order, two cmp_req_o pulses with matching cmp_pc_o, retired_cnt_o=2, level returns to 0.
- **Trap skip.** c0 pc=0x80000010 with trap=1 → one step, no cmp_req_o, retired_cnt_o=1.
- **Overflow.** DEPTH=16, ready=0; 8 cycles of dual commits fill the FIFO; a 9th dual commit → halt_o=1, err_code_o=1, level stays 16, no further steps.
- **Order error and reset recovery.** c1_valid_i=1 with c0_valid_i=0 → err_code_o=2, halt_o=1. Assert arst_i low mid-halt → all outputs 0; a subsequent dual commit is stepped normally.
- **Mismatch under backpressure.** ready toggles 0/1 → pc held stable while ready=0; first compare returns cmp_pass_i=0 → err_code_o=3, retired_cnt_o unchanged, later commits ignored.
- **Timeout.** TIMEOUT=8; one commit, then idle → halt_o=1, err_code_o=4 at the expected cycle. With no commit at all after reset → never halts.
